seq_code_monitor: RTL and testbench
===================================

# seq_code_monitor

Checks the 4-bit code stream from the custom T-flip-flop sequence counter against that counter's fixed 11-state sequence. It acquires and locks onto the sequence, flags every break in it, and counts completed sequence wraps and errors. It sits directly downstream of the counter in the same clock domain and gives the rest of the design a registered health and progress indication.

## Interface
- LOCK_N, 3, consecutive correct successors required to declare lock (legal 1..15)
- ERR_W, 8, width of err_count (saturating)
- WRAP_W, 8, width of wrap_count (wrapping)

- clk  in  1  single clock, all logic on rising edge
- clear  in  1  synchronous, active-high reset; one clock, synchronous active-high reset, no other resets
- valid  in  1  code is sampled on this edge; low means idle
- code  in  4  counter state q[3:0]
- locked  out  1  monitor is locked to the sequence
- expected  out  4  predicted next code
- err_pulse  out  1  one-cycle sequence-break flag
- wrap_pulse  out  1  one-cycle completed-sequence flag
- err_count  out  ERR_W  saturating count of sequence breaks
- wrap_count  out  WRAP_W  modulo count of sequence wraps

## Operation
- Sequence, hex, cyclic: 0→1→F→2→E→3→D→4→C→7→B→0. succ() is this fixed table. Codes 5, 6, 8, 9 and A are illegal.
- States: HUNT, ACQUIRE, LOCKED. Internal run counter has width 4.
- All actions below occur only on edges where valid=1. When valid=0, no state, counter or expected change, and both pulses are 0.
- HUNT:
  - Legal code: expected<=succ(code), run<=0, go to ACQUIRE.
  - Illegal code: stay in HUNT. No error is counted.
- ACQUIRE:
  - code==expected: run<=run+1 and expected<=succ(code). If run+1==LOCK_N, go to LOCKED and set locked<=1.
  - Legal mismatch: expected<=succ(code), run<=0, stay in ACQUIRE.
  - Illegal code: go to HUNT, run<=0.
  - No error is counted in ACQUIRE.
- LOCKED:
  - code==expected: expected<=succ(code). If code==0 (the B→0 transition), wrap_pulse<=1 and wrap_count<=wrap_count+1 mod 2^WRAP_W.
  - Any mismatch: err_pulse<=1, err_count<=min(err_count+1, 2^ERR_W−1), locked<=0, run<=0.
    - If code is legal, expected<=succ(code) and go to ACQUIRE.
    - If code is illegal, go to HUNT and expected holds its value.
- Wraps are counted only in LOCKED. Errors are counted only when leaving LOCKED.
- In HUNT after an illegal code, expected holds its last value.

## Timing
- Reset values: state HUNT, locked=0, expected=0, err_pulse=0, wrap_pulse=0, err_count=0, wrap_count=0, run=0.
- clear takes priority over valid on the same edge: no pulse, no count.
- Latency is 1 cycle. All outputs are registered and change on the edge that samples code.
- Pulses are high for exactly the one cycle after the sampling edge. Back-to-back valid every cycle is supported.
- locked rises after the edge of the (LOCK_N+1)-th consecutive in-sequence sample counted from HUNT: 1 entry sample plus LOCK_N matches.
- Clear while locked drops locked the next cycle. Counters are lost.

## Test plan
- Full sequence after clear, LOCK_N=3, valid=1 every cycle: feed 0,1,F,2,E,3,D,4,C,7,B,0.
  - locked=1 after the 4th sample (2).
  - expected=E after that sample.
  - wrap_pulse for one cycle after the final 0; wrap_count=1, err_count=0.
- Illegal injection while locked: send 5 in place of the expected code.
  - err_pulse for one cycle, err_count=1, locked=0, state HUNT.
  - A following 3 enters ACQUIRE with expected=D.
- Skip while locked: after 2, send 3 instead of E.
  - err_count increments; expected=D.
  - Then D,4,C relocks with locked=1 after C.
- Idle gaps: interleave valid=0 cycles carrying random codes (including illegal ones) within a locked sequence.
  - No pulses, counters and expected unchanged; lock is held.
- Saturation with ERR_W=2: force 5 separate lock-then-break episodes.
  - err_count reads 1,2,3,3,3.
  - err_pulse still fires on each break.
- Clear collision: while locked, assert clear on the same edge as a mismatching valid sample.
  - Next cycle all outputs are 0 and err_pulse=0.
  - A subsequent 0 enters ACQUIRE.

Source files
------------

// File: rtl/seq_code_monitor_if.sv
// Bus between the T-flip-flop sequence counter and its monitor.
// The code stream enters on valid/code and the health/progress outputs return.
interface seq_code_monitor_if #(
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 8
);
  logic              valid;
  logic [3:0]        code;
  logic              locked;
  logic [3:0]        expected;
  logic              err_pulse;
  logic              wrap_pulse;
  logic [ERR_W-1:0]  err_count;
  logic [WRAP_W-1:0] wrap_count;

  modport master (
    output valid, code,
    input  locked, expected, err_pulse, wrap_pulse, err_count, wrap_count
  );

  modport slave (
    input  valid, code,
    output locked, expected, err_pulse, wrap_pulse, err_count, wrap_count
  );
endinterface

// File: rtl/seq_code_monitor.sv
// Sequence monitor for the 11-state T-flip-flop counter.
// It hunts for a legal code and then acquires LOCK_N consecutive correct
// successors. Once locked, it flags every break and counts completed wraps.
// All outputs are registered, with one cycle of latency from the sampling edge.
module seq_code_monitor #(
  parameter int LOCK_N = 3,
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 8
) (
  input  logic               clk,
  input  logic               clear,
  seq_code_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Successor table of the counter: 0-1-F-2-E-3-D-4-C-7-B-0.
  function automatic logic [3:0] succ(input logic [3:0] c);
    logic [3:0] s;
    case (c)
      4'h0:    s = 4'h1;
      4'h1:    s = 4'hF;
      4'hF:    s = 4'h2;
      4'h2:    s = 4'hE;
      4'hE:    s = 4'h3;
      4'h3:    s = 4'hD;
      4'hD:    s = 4'h4;
      4'h4:    s = 4'hC;
      4'hC:    s = 4'h7;
      4'h7:    s = 4'hB;
      4'hB:    s = 4'h0;
      default: s = 4'h0;
    endcase
    return s;
  endfunction

  // The counter can never produce the codes 5, 6, 8, 9 or A.
  function automatic logic is_legal(input logic [3:0] c);
    return !(c == 4'h5 || c == 4'h6 || c == 4'h8 || c == 4'h9 || c == 4'hA);
  endfunction

  // The error count sticks at all-ones instead of rolling over.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Stage p0: sampled inputs and combinational next values
  logic              vld_p0;
  logic [3:0]        code_p0;
  state_t            state_p0;
  logic [3:0]        run_p0;
  logic [3:0]        exp_p0;
  logic              locked_p0;
  logic              err_p0;
  logic              wrap_p0;
  logic [ERR_W-1:0]  errc_p0;
  logic [WRAP_W-1:0] wrapc_p0;

  // Stage p1: registered state and outputs
  state_t            state_p1;
  logic [3:0]        run_p1;
  logic [3:0]        exp_p1;
  logic              locked_p1;
  logic              err_p1;
  logic              wrap_p1;
  logic [ERR_W-1:0]  errc_p1;
  logic [WRAP_W-1:0] wrapc_p1;

  assign vld_p0  = bus.valid;
  assign code_p0 = bus.code;

  // Next-state logic; an idle cycle holds everything and drops both pulses.
  always_comb begin
    state_p0  = state_p1;
    run_p0    = run_p1;
    exp_p0    = exp_p1;
    locked_p0 = locked_p1;
    err_p0    = 1'b0;
    wrap_p0   = 1'b0;
    errc_p0   = errc_p1;
    wrapc_p0  = wrapc_p1;
    if (vld_p0) begin
      case (state_p1)
        HUNT: begin
          if (is_legal(code_p0)) begin
            exp_p0   = succ(code_p0);
            run_p0   = 4'd0;
            state_p0 = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (code_p0 == exp_p1) begin
            run_p0 = run_p1 + 4'd1;
            exp_p0 = succ(code_p0);
            if (run_p0 == 4'(LOCK_N)) begin
              state_p0  = LOCKED;
              locked_p0 = 1'b1;
            end
          end else if (is_legal(code_p0)) begin
            exp_p0 = succ(code_p0);
            run_p0 = 4'd0;
          end else begin
            state_p0 = HUNT;
            run_p0   = 4'd0;
          end
        end
        LOCKED: begin
          if (code_p0 == exp_p1) begin
            exp_p0 = succ(code_p0);
            if (code_p0 == 4'h0) begin
              wrap_p0  = 1'b1;
              wrapc_p0 = wrapc_p1 + 1'b1;
            end
          end else begin
            err_p0    = 1'b1;
            errc_p0   = sat_inc(errc_p1);
            locked_p0 = 1'b0;
            run_p0    = 4'd0;
            if (is_legal(code_p0)) begin
              exp_p0   = succ(code_p0);
              state_p0 = ACQUIRE;
            end else begin
              state_p0 = HUNT;
            end
          end
        end
        default: begin
          state_p0 = HUNT;
          run_p0   = 4'd0;
        end
      endcase
    end
  end

  // State register; clear wins over a valid sample on the same edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_p1  <= HUNT;
      run_p1    <= 4'd0;
      exp_p1    <= 4'h0;
      locked_p1 <= 1'b0;
      err_p1    <= 1'b0;
      wrap_p1   <= 1'b0;
      errc_p1   <= '0;
      wrapc_p1  <= '0;
    end else begin
      state_p1  <= state_p0;
      run_p1    <= run_p0;
      exp_p1    <= exp_p0;
      locked_p1 <= locked_p0;
      err_p1    <= err_p0;
      wrap_p1   <= wrap_p0;
      errc_p1   <= errc_p0;
      wrapc_p1  <= wrapc_p0;
    end
  end

  assign bus.locked     = locked_p1;
  assign bus.expected   = exp_p1;
  assign bus.err_pulse  = err_p1;
  assign bus.wrap_pulse = wrap_p1;
  assign bus.err_count  = errc_p1;
  assign bus.wrap_count = wrapc_p1;

endmodule

// File: tb/tb_seq_code_monitor.sv
// Bench for seq_code_monitor: two instances share one stimulus stream.
// Instance 0 uses an 8-bit error count and instance 1 a 2-bit saturating one.
// A reference model built on the sequence table predicts every output each cycle.
module tb_seq_code_monitor;

  localparam int LOCK_N = 3;

  logic       clk = 1'b0;
  logic       t_clear = 1'b1;
  logic       t_valid = 1'b0;
  logic [3:0] t_code  = 4'h0;

  int n_vec = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  seq_code_monitor_if #(.ERR_W(8), .WRAP_W(8)) ifc0 ();
  seq_code_monitor_if #(.ERR_W(2), .WRAP_W(8)) ifc1 ();

  assign ifc0.valid = t_valid;
  assign ifc0.code  = t_code;
  assign ifc1.valid = t_valid;
  assign ifc1.code  = t_code;

  seq_code_monitor #(.LOCK_N(LOCK_N), .ERR_W(8), .WRAP_W(8)) u_dut (
    .clk(clk), .clear(t_clear), .bus(ifc0.slave));

  seq_code_monitor #(.LOCK_N(LOCK_N), .ERR_W(2), .WRAP_W(8)) u_sat (
    .clk(clk), .clear(t_clear), .bus(ifc1.slave));

  // Reference model: position in the cyclic sequence drives everything.
  int seq [11] = '{0, 1, 15, 2, 14, 3, 13, 4, 12, 7, 11};
  int em  [2]  = '{255, 3};

  int m_mode  [2];
  int m_exp   [2];
  int m_run   [2];
  int m_lock  [2];
  int m_errp  [2];
  int m_wrapp [2];
  int m_errc  [2];
  int m_wrapc [2];

  function automatic int pos_of(input int c);
    for (int i = 0; i < 11; i++) if (seq[i] == c) return i;
    return -1;
  endfunction

  function automatic int nxt(input int c);
    return seq[(pos_of(c) + 1) % 11];
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_exp[k] = 0; m_run[k] = 0; m_lock[k] = 0;
      m_errp[k] = 0; m_wrapp[k] = 0; m_errc[k] = 0; m_wrapc[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input int c);
    bit legal;
    legal = (pos_of(c) >= 0);
    case (m_mode[k])
      0: if (legal) begin m_exp[k] = nxt(c); m_run[k] = 0; m_mode[k] = 1; end
      1: begin
        if (c == m_exp[k]) begin
          m_run[k]++;
          m_exp[k] = nxt(c);
          if (m_run[k] == LOCK_N) begin m_mode[k] = 2; m_lock[k] = 1; end
        end else if (legal) begin
          m_exp[k] = nxt(c); m_run[k] = 0;
        end else begin
          m_mode[k] = 0; m_run[k] = 0;
        end
      end
      default: begin
        if (c == m_exp[k]) begin
          m_exp[k] = nxt(c);
          if (c == 0) begin m_wrapp[k] = 1; m_wrapc[k] = (m_wrapc[k] + 1) % 256; end
        end else begin
          m_errp[k] = 1;
          if (m_errc[k] < em[k]) m_errc[k]++;
          m_lock[k] = 0; m_run[k] = 0;
          if (legal) begin m_exp[k] = nxt(c); m_mode[k] = 1; end
          else m_mode[k] = 0;
        end
      end
    endcase
  endtask

  // Single compare process: advance the model on each edge, then check both DUTs.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin m_errp[k] = 0; m_wrapp[k] = 0; end
    if (t_clear) begin
      model_reset();
      started = 1'b1;
    end else if (t_valid) begin
      for (int k = 0; k < 2; k++) model_step(k, int'(t_code));
    end
    #1;
    if (started) begin
      n_vec++;
      cmp("i0.locked",     32'(ifc0.locked),     32'(m_lock[0]));
      cmp("i0.expected",   32'(ifc0.expected),   32'(m_exp[0]));
      cmp("i0.err_pulse",  32'(ifc0.err_pulse),  32'(m_errp[0]));
      cmp("i0.wrap_pulse", 32'(ifc0.wrap_pulse), 32'(m_wrapp[0]));
      cmp("i0.err_count",  32'(ifc0.err_count),  32'(m_errc[0]));
      cmp("i0.wrap_count", 32'(ifc0.wrap_count), 32'(m_wrapc[0]));
      cmp("i1.locked",     32'(ifc1.locked),     32'(m_lock[1]));
      cmp("i1.expected",   32'(ifc1.expected),   32'(m_exp[1]));
      cmp("i1.err_pulse",  32'(ifc1.err_pulse),  32'(m_errp[1]));
      cmp("i1.wrap_pulse", 32'(ifc1.wrap_pulse), 32'(m_wrapp[1]));
      cmp("i1.err_count",  32'(ifc1.err_count),  32'(m_errc[1]));
      cmp("i1.wrap_count", 32'(ifc1.wrap_count), 32'(m_wrapc[1]));
    end
  end

  task automatic step(input bit v, input logic [3:0] c, input bit clr = 1'b0);
    @(negedge clk);
    t_valid = v;
    t_code  = c;
    t_clear = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic lock_up();
    step(1, 4'h0); step(1, 4'h1); step(1, 4'hF); step(1, 4'h2);
  endtask

  int sat_want [5] = '{1, 2, 3, 3, 3};

  initial begin
    int nc;
    step(0, 4'h0, 1);
    step(0, 4'h0, 1);
    cmp("reset.locked",   32'(ifc0.locked),     32'h0);
    cmp("reset.expected", 32'(ifc0.expected),   32'h0);
    cmp("reset.errc",     32'(ifc0.err_count),  32'h0);
    cmp("reset.wrapc",    32'(ifc0.wrap_count), 32'h0);

    // Full sequence: lock after the fourth sample, wrap on the final 0.
    step(1, 4'h0); step(1, 4'h1); step(1, 4'hF);
    cmp("seq.not_yet_locked", 32'(ifc0.locked), 32'h0);
    step(1, 4'h2);
    cmp("seq.locked",   32'(ifc0.locked),   32'h1);
    cmp("seq.expected", 32'(ifc0.expected), 32'hE);
    step(1, 4'hE); step(1, 4'h3); step(1, 4'hD); step(1, 4'h4);
    step(1, 4'hC); step(1, 4'h7); step(1, 4'hB); step(1, 4'h0);
    cmp("seq.wrap_pulse", 32'(ifc0.wrap_pulse), 32'h1);
    cmp("seq.wrap_count", 32'(ifc0.wrap_count), 32'h1);
    cmp("seq.err_count",  32'(ifc0.err_count),  32'h0);

    // Illegal injection while locked.
    step(1, 4'h5);
    cmp("ill.err_pulse", 32'(ifc0.err_pulse),  32'h1);
    cmp("ill.err_count", 32'(ifc0.err_count),  32'h1);
    cmp("ill.locked",    32'(ifc0.locked),     32'h0);
    cmp("ill.wrap_pulse_gone", 32'(ifc0.wrap_pulse), 32'h0);
    step(1, 4'h3);
    cmp("ill.expected_after_3", 32'(ifc0.expected),  32'hD);
    cmp("ill.err_pulse_gone",   32'(ifc0.err_pulse), 32'h0);

    // Relock, then skip from 2 to 3.
    step(1, 4'hD); step(1, 4'h4); step(1, 4'hC);
    cmp("relock.locked", 32'(ifc0.locked), 32'h1);
    step(1, 4'h7); step(1, 4'hB); step(1, 4'h0); step(1, 4'h1); step(1, 4'hF); step(1, 4'h2);
    step(1, 4'h3);
    cmp("skip.err_count", 32'(ifc0.err_count), 32'h2);
    cmp("skip.expected",  32'(ifc0.expected),  32'hD);
    step(1, 4'hD); step(1, 4'h4);
    cmp("skip.still_unlocked", 32'(ifc0.locked), 32'h0);
    step(1, 4'hC);
    cmp("skip.relocked", 32'(ifc0.locked), 32'h1);

    // Idle gaps carrying junk codes inside a locked run.
    nc = 7;
    for (int r = 0; r < 4; r++) begin
      step(0, 4'($urandom_range(15)));
      step(0, 4'h5);
      cmp("idle.expected_held", 32'(ifc0.expected), 32'(nc));
      cmp("idle.no_err",        32'(ifc0.err_pulse), 32'h0);
      step(1, 4'(nc));
      nc = nxt(nc);
    end
    cmp("idle.locked",     32'(ifc0.locked),     32'h1);
    cmp("idle.wrap_count", 32'(ifc0.wrap_count), 32'h3);

    // Saturation of the 2-bit error counter.
    step(0, 4'h0, 1);
    for (int ep = 0; ep < 5; ep++) begin
      lock_up();
      step(1, 4'h5);
      cmp("sat.err_pulse", 32'(ifc1.err_pulse), 32'h1);
      cmp("sat.err_count", 32'(ifc1.err_count), 32'(sat_want[ep]));
    end

    // Clear colliding with a mismatching sample while locked.
    lock_up();
    step(1, 4'h5, 1);
    cmp("clr.locked",    32'(ifc0.locked),    32'h0);
    cmp("clr.expected",  32'(ifc0.expected),  32'h0);
    cmp("clr.err_pulse", 32'(ifc0.err_pulse), 32'h0);
    cmp("clr.err_count", 32'(ifc0.err_count), 32'h0);
    step(1, 4'h0);
    cmp("clr.acq_expected", 32'(ifc0.expected), 32'h1);
    cmp("clr.acq_unlocked", 32'(ifc0.locked),   32'h0);

    // Randomised run: mostly in-sequence, with idles, corruptions and clears.
    nc = 1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [3:0] c;
      r = int'($urandom_range(99));
      if (r < 15) begin
        step(0, 4'($urandom_range(15)));
      end else if (r < 16) begin
        step(0, 4'h0, 1);
        nc = 0;
      end else begin
        c = (r < 24) ? 4'($urandom_range(15)) : 4'(nc);
        step(1, c);
        nc = (pos_of(int'(c)) >= 0) ? nxt(int'(c)) : 0;
      end
    end

    step(0, 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
